// File: rtl/param_rr_lock_arbiter.sv
// Round-robin / priority-start arbiter with grant locking, hold timeout and a
// mandatory one-cycle gap between grants. All outputs are registered.
module param_rr_lock_arbiter #(
  parameter int N = 8,
  parameter int MAX_HOLD = 16,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             mode,
  input  logic [N-1:0]     prio_onehot,
  input  logic             owner_release,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_grant,
  output logic             timeout
);

  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
  localparam logic HOLD_EN = (MAX_HOLD > 0);
  localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [IDX_W-1:0] ptr_r, ptr_s;
  logic [CNT_W-1:0] hold_cnt_r, hold_cnt_s;
  logic [N-1:0]     grant_r, grant_s;
  logic [IDX_W-1:0] grant_idx_r, grant_idx_s;
  logic             any_grant_r, any_grant_s;
  logic             timeout_r, timeout_s;

  logic [IDX_W-1:0] start_s;
  logic [IDX_W-1:0] scan_idx_s;
  logic [IDX_W-1:0] win_idx_s;
  logic             win_found_s;
  logic             hold_expire_s;
  logic             busy_exit_s;

  // (base + off) mod N without relying on N being a power of two
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    sum = (sum >= N) ? (sum - N) : sum;
    return IDX_W'(sum);
  endfunction

  // Search start: internal pointer, or lowest set bit of prio_onehot
  always_comb begin
    start_s = ptr_r;
    if (mode) begin
      start_s = '0;
      for (int i = N - 1; i >= 0; i--) begin
        start_s = prio_onehot[i] ? IDX_W'(i) : start_s;
      end
    end else begin
      start_s = ptr_r;
    end
  end

  // Circular scan of req starting at start_s; first hit wins
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    scan_idx_s  = '0;
    for (int i = 0; i < N; i++) begin
      scan_idx_s  = wrap_idx(start_s, i);
      win_idx_s   = (req[scan_idx_s] && !win_found_s) ? scan_idx_s : win_idx_s;
      win_found_s = win_found_s | req[scan_idx_s];
    end
  end

  // Lock exit causes; release outranks the timeout
  always_comb begin
    hold_expire_s = HOLD_EN && (hold_cnt_r == HOLD_LAST);
    busy_exit_s   = owner_release | ~req[grant_idx_r] | hold_expire_s;
  end

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      ptr_r       <= '0;
      hold_cnt_r  <= '0;
      grant_r     <= '0;
      grant_idx_r <= '0;
      any_grant_r <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      hold_cnt_r  <= hold_cnt_s;
      grant_r     <= grant_s;
      grant_idx_r <= grant_idx_s;
      any_grant_r <= any_grant_s;
      timeout_r   <= timeout_s;
    end
  end

  // Next-state logic; GAP arbitrates exactly like IDLE
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, GAP: state_s = win_found_s ? BUSY : IDLE;
      BUSY:      state_s = busy_exit_s ? GAP : BUSY;
      default:   state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and hold counter
  always_comb begin
    ptr_s       = ptr_r;
    hold_cnt_s  = hold_cnt_r;
    grant_s     = '0;
    grant_idx_s = '0;
    any_grant_s = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      IDLE, GAP: begin
        if (win_found_s) begin
          grant_s     = ONE_N << win_idx_s;
          grant_idx_s = win_idx_s;
          any_grant_s = 1'b1;
          hold_cnt_s  = '0;
        end else begin
          hold_cnt_s  = '0;
        end
      end
      BUSY: begin
        if (busy_exit_s) begin
          timeout_s  = hold_expire_s & ~owner_release;
          ptr_s      = wrap_idx(grant_idx_r, 1);
          hold_cnt_s = '0;
        end else begin
          grant_s     = grant_r;
          grant_idx_s = grant_idx_r;
          any_grant_s = 1'b1;
          hold_cnt_s  = hold_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        ptr_s      = '0;
        hold_cnt_s = '0;
      end
    endcase
  end

  assign grant     = grant_r;
  assign grant_idx = grant_idx_r;
  assign any_grant = any_grant_r;
  assign timeout   = timeout_r;

endmodule

// File: tb/tb_param_rr_lock_arbiter.sv
// Scoreboard bench for param_rr_lock_arbiter (N=8, MAX_HOLD=4): each driven
// cycle queues the hand-derived outputs expected after the next rising edge.
module tb_param_rr_lock_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       mode = 1'b0;
  logic [7:0] prio_onehot = 8'h00;
  logic       owner_release = 1'b0;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       any_grant;
  logic       timeout;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] g;
    logic [2:0] idx;
    logic       to;
    string      tag;
  } exp_t;

  exp_t sb[$];

  param_rr_lock_arbiter #(.N(8), .MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .mode(mode), .prio_onehot(prio_onehot),
    .owner_release(owner_release), .grant(grant), .grant_idx(grant_idx),
    .any_grant(any_grant), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and queue the expectation
  task automatic step(input logic rn, input logic [7:0] r, input logic m, input logic [7:0] p,
                      input logic rel, input logic [7:0] eg, input logic [2:0] ei,
                      input logic eto, input string tag);
    exp_t e;
    @(negedge clk);
    rst_n = rn;
    req = r;
    mode = m;
    prio_onehot = p;
    owner_release = rel;
    e.g = eg;
    e.idx = ei;
    e.to = eto;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Compare {timeout, any_grant, grant_idx, grant} just after each rising edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, 32'({timeout, any_grant, grant_idx, grant}),
                32'({e.to, (e.g != 8'h00), e.idx, e.g}));
    end
  end

  initial begin
    //    rn    req    m     prio   rel   grant  idx   to
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, "reset");
    step(1'b0, 8'h81, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, "reset_hold");
    step(1'b1, 8'h81, 1'b0, 8'h00, 1'b0, 8'h01, 3'd0, 1'b0, "rr_first");
    step(1'b1, 8'h81, 1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, "gap1");
    step(1'b1, 8'h81, 1'b0, 8'h00, 1'b0, 8'h80, 3'd7, 1'b0, "rr_second");
    step(1'b1, 8'h81, 1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, "gap2");
    step(1'b1, 8'h81, 1'b0, 8'h00, 1'b0, 8'h01, 3'd0, 1'b0, "rr_wrap");
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, "gap3");
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, "idle_no_req");
    step(1'b1, 8'h25, 1'b1, 8'h10, 1'b0, 8'h20, 3'd5, 1'b0, "prio_10");
    step(1'b1, 8'h25, 1'b1, 8'h10, 1'b1, 8'h00, 3'd0, 1'b0, "gap4");
    step(1'b1, 8'h25, 1'b1, 8'h80, 1'b0, 8'h01, 3'd0, 1'b0, "prio_80");
    step(1'b1, 8'h25, 1'b1, 8'h80, 1'b1, 8'h00, 3'd0, 1'b0, "gap5");
    // hold timeout: grant visible exactly 4 cycles, then revoked
    step(1'b1, 8'h04, 1'b0, 8'h00, 1'b0, 8'h04, 3'd2, 1'b0, "hold1");
    step(1'b1, 8'h04, 1'b0, 8'h00, 1'b0, 8'h04, 3'd2, 1'b0, "hold2");
    step(1'b1, 8'h04, 1'b0, 8'h00, 1'b0, 8'h04, 3'd2, 1'b0, "hold3");
    step(1'b1, 8'h04, 1'b0, 8'h00, 1'b0, 8'h04, 3'd2, 1'b0, "hold4");
    step(1'b1, 8'h04, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b1, "timeout");
    step(1'b1, 8'h04, 1'b0, 8'h00, 1'b0, 8'h04, 3'd2, 1'b0, "regrant");
    step(1'b1, 8'h04, 1'b0, 8'h00, 1'b0, 8'h04, 3'd2, 1'b0, "rehold2");
    step(1'b1, 8'h04, 1'b0, 8'h00, 1'b0, 8'h04, 3'd2, 1'b0, "rehold3");
    step(1'b1, 8'h04, 1'b0, 8'h00, 1'b0, 8'h04, 3'd2, 1'b0, "rehold4");
    step(1'b1, 8'h04, 1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, "rel_beats_timeout");
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, "gap_idle");
    // owner drops its request; mode/prio changes while busy are ignored
    step(1'b1, 8'h42, 1'b0, 8'h00, 1'b0, 8'h40, 3'd6, 1'b0, "drop_grant");
    step(1'b1, 8'h02, 1'b1, 8'h01, 1'b0, 8'h00, 3'd0, 1'b0, "owner_drop");
    step(1'b1, 8'h82, 1'b0, 8'h00, 1'b0, 8'h80, 3'd7, 1'b0, "ptr_after_drop");
    step(1'b1, 8'h83, 1'b1, 8'h02, 1'b0, 8'h80, 3'd7, 1'b0, "busy_stable");
    step(1'b1, 8'h83, 1'b1, 8'h02, 1'b1, 8'h00, 3'd0, 1'b0, "gap6");
    step(1'b1, 8'h11, 1'b1, 8'h28, 1'b0, 8'h10, 3'd4, 1'b0, "prio_multihot");
    step(1'b1, 8'h11, 1'b1, 8'h28, 1'b1, 8'h00, 3'd0, 1'b0, "gap7");
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, "rel_in_gap");
    step(1'b1, 8'h02, 1'b0, 8'h00, 1'b0, 8'h02, 3'd1, 1'b0, "grant_02");
    step(1'b1, 8'h02, 1'b0, 8'h00, 1'b0, 8'h02, 3'd1, 1'b0, "grant_02_hold");
    // reset in the middle of a grant
    step(1'b0, 8'h02, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, "mid_reset");
    step(1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h01, 3'd0, 1'b0, "post_reset");
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, "final_gap");
    @(posedge clk);
    #2;
    check_val("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
